// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: signed pre-add / multiply / post-add MAC pipeline with framed
// accumulation, beat counter and sticky overflow.
//
// Compile-time option: define DSP_MAC_SAT_EN to clamp P on overflow instead of
// letting it wrap modulo 2^P_WIDTH. OVF is set in both builds.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset of all state
//   ce_i         clock enable; low freezes every register
//   in_valid_i   sample qualifier
//   in_last_i    final beat of a frame (ignored unless in_valid_i)
//   mode_i       [0] pre-add enable, [1] pre-subtract, [3:2] Z select
//   a_i          multiplier operand (A_WIDTH, signed)
//   b_i, d_i     pre-adder operands (B_WIDTH, signed)
//   c_i          post-adder operand (C_WIDTH, signed)
//   pcin_i       cascade input (P_WIDTH)
//   p_o          registered accumulator
//   pcout_o      cascade output, equals p_o
//   out_valid_o  one-cycle pulse: p_o holds a completed frame result
//   out_cnt_o    beat count of the frame just completed
//   ovf_o        sticky signed overflow of the current/last frame
module dsp_mac_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int C_WIDTH   = 48,
  parameter int P_WIDTH   = 48,
  parameter int IN_REG    = 1,
  parameter int MREG      = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ce_i,
  input  logic                        in_valid_i,
  input  logic                        in_last_i,
  input  logic [3:0]                  mode_i,
  input  logic signed [A_WIDTH-1:0]   a_i,
  input  logic signed [B_WIDTH-1:0]   b_i,
  input  logic signed [B_WIDTH-1:0]   d_i,
  input  logic signed [C_WIDTH-1:0]   c_i,
  input  logic signed [P_WIDTH-1:0]   pcin_i,
  output logic signed [P_WIDTH-1:0]   p_o,
  output logic signed [P_WIDTH-1:0]   pcout_o,
  output logic                        out_valid_o,
  output logic [CNT_WIDTH-1:0]        out_cnt_o,
  output logic                        ovf_o
);
  localparam int M_WIDTH = A_WIDTH + B_WIDTH + 1;

  if (P_WIDTH < M_WIDTH) begin : g_width_check
    $error("dsp_mac_pipe: P_WIDTH must be >= A_WIDTH+B_WIDTH+1");
  end

  // ---------------- stage 0: optional input register ----------------
  logic                      s0_valid, s0_last;
  logic [3:0]                s0_mode;
  logic signed [A_WIDTH-1:0] s0_a;
  logic signed [B_WIDTH-1:0] s0_b, s0_d;
  logic signed [C_WIDTH-1:0] s0_c;

  if (IN_REG != 0) begin : g_in_reg
    logic                      valid_q, last_q;
    logic [3:0]                mode_q;
    logic signed [A_WIDTH-1:0] a_q;
    logic signed [B_WIDTH-1:0] b_q, d_q;
    logic signed [C_WIDTH-1:0] c_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        mode_q  <= '0;
        a_q     <= '0;
        b_q     <= '0;
        d_q     <= '0;
        c_q     <= '0;
      end else if (ce_i) begin
        valid_q <= in_valid_i;
        last_q  <= in_last_i;
        mode_q  <= mode_i;
        a_q     <= a_i;
        b_q     <= b_i;
        d_q     <= d_i;
        c_q     <= c_i;
      end
    end
    assign s0_valid = valid_q;
    assign s0_last  = last_q;
    assign s0_mode  = mode_q;
    assign s0_a     = a_q;
    assign s0_b     = b_q;
    assign s0_d     = d_q;
    assign s0_c     = c_q;
  end else begin : g_in_bypass
    assign s0_valid = in_valid_i;
    assign s0_last  = in_last_i;
    assign s0_mode  = mode_i;
    assign s0_a     = a_i;
    assign s0_b     = b_i;
    assign s0_d     = d_i;
    assign s0_c     = c_i;
  end

  // ---------------- stage 1: pre-adder and multiplier ----------------
  logic signed [B_WIDTH:0]   pre_s;
  logic signed [M_WIDTH-1:0] m_s;

  always_comb begin
    pre_s = (B_WIDTH+1)'(s0_b);
    if (s0_mode[0]) begin
      if (s0_mode[1]) pre_s = (B_WIDTH+1)'(s0_d) - (B_WIDTH+1)'(s0_b);
      else            pre_s = (B_WIDTH+1)'(s0_d) + (B_WIDTH+1)'(s0_b);
    end
  end

  // Both operands are signed, so the casts sign-extend before multiplying.
  assign m_s = M_WIDTH'(s0_a) * M_WIDTH'(pre_s);

  logic                      s1_valid, s1_last;
  logic [1:0]                s1_zsel;
  logic signed [M_WIDTH-1:0] s1_m;
  logic signed [C_WIDTH-1:0] s1_c;

  if (MREG != 0) begin : g_m_reg
    logic                      valid_q, last_q;
    logic [1:0]                zsel_q;
    logic signed [M_WIDTH-1:0] m_q;
    logic signed [C_WIDTH-1:0] c_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        zsel_q  <= '0;
        m_q     <= '0;
        c_q     <= '0;
      end else if (ce_i) begin
        valid_q <= s0_valid;
        last_q  <= s0_last;
        zsel_q  <= s0_mode[3:2];
        m_q     <= m_s;
        c_q     <= s0_c;
      end
    end
    assign s1_valid = valid_q;
    assign s1_last  = last_q;
    assign s1_zsel  = zsel_q;
    assign s1_m     = m_q;
    assign s1_c     = c_q;
  end else begin : g_m_bypass
    assign s1_valid = s0_valid;
    assign s1_last  = s0_last;
    assign s1_zsel  = s0_mode[3:2];
    assign s1_m     = m_s;
    assign s1_c     = s0_c;
  end

  // ---------------- stage 2: post-adder and accumulator ----------------
  logic signed [P_WIDTH-1:0] p_q, p_d, z_s;
  logic signed [P_WIDTH:0]   sum_s;
  logic                      beat_ovf;
  logic [CNT_WIDTH-1:0]      cnt_q, out_cnt_q;
  logic                      in_frame_q, out_valid_q, ovf_q;

  always_comb begin
    z_s = '0;
    case (s1_zsel)
      // A frame's first beat never feeds back the previous frame's result.
      2'b00:   z_s = in_frame_q ? p_q : '0;
      2'b01:   z_s = '0;
      2'b10:   z_s = P_WIDTH'(s1_c);
      default: z_s = pcin_i;
    endcase
    // One extra bit so the carry into the sign position is visible.
    sum_s    = (P_WIDTH+1)'(z_s) + (P_WIDTH+1)'(s1_m);
    beat_ovf = sum_s[P_WIDTH] ^ sum_s[P_WIDTH-1];
`ifdef DSP_MAC_SAT_EN
    if (beat_ovf)
      p_d = sum_s[P_WIDTH] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
    else
      p_d = sum_s[P_WIDTH-1:0];
`else
    p_d = sum_s[P_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q         <= '0;
      cnt_q       <= '0;
      out_cnt_q   <= '0;
      in_frame_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (ce_i) begin
      out_valid_q <= s1_valid & s1_last;
      if (s1_valid) begin
        p_q   <= p_d;
        // Sticky within a frame, restarted on the frame's first beat.
        ovf_q <= beat_ovf | (in_frame_q & ovf_q);
        if (s1_last) begin
          out_cnt_q  <= cnt_q + CNT_WIDTH'(1);
          cnt_q      <= '0;
          in_frame_q <= 1'b0;
        end else begin
          cnt_q      <= cnt_q + CNT_WIDTH'(1);
          in_frame_q <= 1'b1;
        end
      end
    end
  end

  assign p_o         = p_q;
  assign pcout_o     = p_q;
  assign out_valid_o = out_valid_q;
  assign out_cnt_o   = out_cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Testbench for dsp_mac_pipe: a default 48-bit instance and a 40-bit instance
// driven by the same stimulus, checked every cycle against a transaction-level
// model, plus a directed vector table and hand-written overflow/reset sequences.
module tb_dsp_mac_pipe;

`ifdef DSP_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, ce, v, l;
  logic [3:0] mode;
  logic signed [17:0] a, b, d;
  logic signed [47:0] c, pcin;
  logic signed [39:0] c40, pcin40;
  logic signed [47:0] p0, pc0;
  logic signed [39:0] p1, pc1;
  logic ov0, ov1, ovf0, ovf1;
  logic [7:0] cnt0, cnt1;

  assign c40    = c[39:0];
  assign pcin40 = pcin[39:0];

  always #5 clk = ~clk;

  dsp_mac_pipe u_dut (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(v), .in_last_i(l),
    .mode_i(mode), .a_i(a), .b_i(b), .d_i(d), .c_i(c), .pcin_i(pcin),
    .p_o(p0), .pcout_o(pc0), .out_valid_o(ov0), .out_cnt_o(cnt0), .ovf_o(ovf0)
  );

  dsp_mac_pipe #(.C_WIDTH(40), .P_WIDTH(40)) u_dut40 (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(v), .in_last_i(l),
    .mode_i(mode), .a_i(a), .b_i(b), .d_i(d), .c_i(c40), .pcin_i(pcin40),
    .p_o(p1), .pcout_o(pc1), .out_valid_o(ov1), .out_cnt_o(cnt1), .ovf_o(ovf1)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cycle, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Beats enter a delay line on every enabled edge and emerge LAT-1 enabled
  // edges later, where the frame rules are applied with plain arithmetic.
  typedef struct {
    bit v, l;
    bit [3:0] mode;
    longint a, b, d, c;
  } beat_t;

  localparam int LAT = 3;
  beat_t  pq[$];
  longint mp[2];
  int     mcnt[2], moc[2];
  bit     movf[2], mov[2], minfr[2];

  function automatic longint sext(longint x, int w);
    return (x <<< (64 - w)) >>> (64 - w);
  endfunction

  task automatic model_reset();
    beat_t e;
    e = '{v: 0, l: 0, mode: 0, a: 0, b: 0, d: 0, c: 0};
    pq.delete();
    for (int k = 0; k < LAT - 1; k++) pq.push_back(e);
    for (int i = 0; i < 2; i++) begin
      mp[i] = 0; mcnt[i] = 0; moc[i] = 0;
      movf[i] = 0; mov[i] = 0; minfr[i] = 0;
    end
  endtask

  task automatic model_apply(input int i, input beat_t bt, input longint pc);
    int pw;
    longint pmax, pmin, pre, m, z, s;
    bit ovb;
    pw   = (i == 0) ? 48 : 40;
    pmax = (64'sd1 <<< (pw - 1)) - 1;
    pmin = -pmax - 1;
    if (!bt.v) begin
      mov[i] = 0;
      return;
    end
    pre = bt.mode[0] ? (bt.mode[1] ? bt.d - bt.b : bt.d + bt.b) : bt.b;
    m = bt.a * pre;
    case (bt.mode[3:2])
      2'd0:    z = minfr[i] ? mp[i] : 0;
      2'd1:    z = 0;
      2'd2:    z = sext(bt.c, pw);
      default: z = sext(pc, pw);
    endcase
    s = z + m;
    ovb = (s > pmax) || (s < pmin);
    if (ovb) mp[i] = SAT ? ((s < 0) ? pmin : pmax) : sext(s, pw);
    else     mp[i] = s;
    movf[i] = minfr[i] ? (movf[i] | ovb) : ovb;
    if (bt.l) begin
      moc[i]   = (mcnt[i] + 1) % 256;
      mcnt[i]  = 0;
      minfr[i] = 0;
    end else begin
      mcnt[i]  = (mcnt[i] + 1) % 256;
      minfr[i] = 1;
    end
    mov[i] = bt.l;
  endtask

  task automatic model_step();
    beat_t nb, bt;
    if (rst) begin
      model_reset();
    end else if (ce) begin
      nb.v = v; nb.l = l; nb.mode = mode;
      nb.a = longint'(a); nb.b = longint'(b); nb.d = longint'(d); nb.c = longint'(c);
      pq.push_back(nb);
      bt = pq.pop_front();
      for (int i = 0; i < 2; i++) model_apply(i, bt, longint'(pcin));
    end
  endtask

  task automatic model_check();
    chk("m0_p", longint'(p0), mp[0]);
    chk("m0_pcout", longint'(pc0), mp[0]);
    chk("m0_out_valid", longint'(ov0), longint'(mov[0]));
    chk("m0_out_cnt", longint'(cnt0), longint'(moc[0]));
    chk("m0_ovf", longint'(ovf0), longint'(movf[0]));
    chk("m1_p", longint'(p1), mp[1]);
    chk("m1_pcout", longint'(pc1), mp[1]);
    chk("m1_out_valid", longint'(ov1), longint'(mov[1]));
    chk("m1_out_cnt", longint'(cnt1), longint'(moc[1]));
    chk("m1_ovf", longint'(ovf1), longint'(movf[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cycle++;
    model_check();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, ce, v, l;
    bit [3:0] mode;
    int a, b, d;
    longint c;
    bit chk;
    longint ep;
    bit eov;
    int ecnt;
    bit eovf;
  } vec_t;

  localparam int NROW = 33;
  vec_t tbl[NROW];

  function automatic vec_t idle();
    vec_t r;
    r = '{rst: 0, ce: 1, v: 0, l: 0, mode: 0, a: 0, b: 0, d: 0, c: 0,
          chk: 0, ep: 0, eov: 0, ecnt: 0, eovf: 0};
    return r;
  endfunction

  function automatic vec_t beat(bit last, bit [3:0] md, int aa, int bb, int dd, longint cc);
    vec_t r;
    r = idle();
    r.v = 1; r.l = last; r.mode = md; r.a = aa; r.b = bb; r.d = dd; r.c = cc;
    return r;
  endfunction

  task automatic expect_row(input int i, input longint p, input bit ovv, input int cn, input bit of);
    tbl[i].chk = 1; tbl[i].ep = p; tbl[i].eov = ovv; tbl[i].ecnt = cn; tbl[i].eovf = of;
  endtask

  task automatic build_table();
    for (int i = 0; i < NROW; i++) tbl[i] = idle();
    tbl[0] = beat(1, 4'b0100, 3, 4, 0, 0);
    expect_row(2, 12, 1, 1, 0);
    expect_row(3, 12, 0, 1, 0);
    for (int i = 4; i < 7; i++) tbl[i] = beat(0, 4'b0000, 2, 5, 0, 0);
    tbl[7] = beat(1, 4'b0000, 2, 5, 0, 0);
    tbl[8] = beat(1, 4'b0000, 1, 1, 0, 0);
    expect_row(8, 30, 0, 1, 0);
    expect_row(9, 40, 1, 4, 0);
    expect_row(10, 1, 1, 1, 0);
    tbl[11] = beat(1, 4'b0011, -2, 3, 10, 0);
    tbl[12] = beat(1, 4'b1001, 1, 3, 10, 100);
    expect_row(13, -14, 1, 1, 0);
    expect_row(14, 113, 1, 1, 0);
    tbl[15] = beat(0, 4'b0000, 1, 1, 0, 0);
    tbl[16].a = 9;
    tbl[17] = beat(1, 4'b0000, 7, 7, 0, 0);
    tbl[17].ce = 0;
    expect_row(17, 113, 0, 1, 0);
    tbl[18] = beat(0, 4'b0000, 1, 1, 0, 0);
    tbl[19] = beat(1, 4'b0000, 7, 7, 0, 0);
    tbl[19].ce = 0;
    expect_row(19, 1, 0, 1, 0);
    tbl[20] = beat(1, 4'b0000, 1, 1, 0, 0);
    expect_row(22, 3, 1, 3, 0);
    tbl[23].ce = 0;
    expect_row(23, 3, 1, 3, 0);
    expect_row(24, 3, 0, 3, 0);
    tbl[25] = beat(0, 4'b0000, 1, 1, 0, 0);
    tbl[26] = beat(0, 4'b0000, 1, 1, 0, 0);
    expect_row(28, 2, 0, 3, 0);
    tbl[29].rst = 1;
    expect_row(29, 0, 0, 0, 0);
    tbl[30] = beat(1, 4'b0000, 5, 5, 0, 0);
    expect_row(32, 25, 1, 1, 0);
  endtask

  task automatic drive(input vec_t r);
    rst = r.rst; ce = r.ce; v = r.v; l = r.l; mode = r.mode;
    a = 18'(r.a); b = 18'(r.b); d = 18'(r.d); c = 48'(r.c); pcin = '0;
  endtask

  task automatic drive_beat(input bit last, input int aa, input int bb);
    v = 1; l = last; mode = 4'b0000; a = 18'(aa); b = 18'(bb); d = '0; c = '0;
  endtask

  initial begin
    rst = 1; ce = 1; v = 0; l = 0; mode = '0;
    a = '0; b = '0; d = '0; c = '0; pcin = '0;
    model_reset();
    tick();
    tick();
    chk("reset_p", longint'(p0), 0);
    chk("reset_out_valid", longint'(ov0), 0);
    chk("reset_out_cnt", longint'(cnt0), 0);
    chk("reset_ovf", longint'(ovf0), 0);
    rst = 0;

    build_table();
    for (int i = 0; i < NROW; i++) begin
      drive(tbl[i]);
      tick();
      if (tbl[i].chk) begin
        chk($sformatf("row%0d_p", i), longint'(p0), tbl[i].ep);
        chk($sformatf("row%0d_out_valid", i), longint'(ov0), longint'(tbl[i].eov));
        chk($sformatf("row%0d_out_cnt", i), longint'(cnt0), longint'(tbl[i].ecnt));
        chk($sformatf("row%0d_ovf", i), longint'(ovf0), longint'(tbl[i].eovf));
      end
    end

    // Overflow on the 40-bit instance: 32 beats of 131071^2 still fit, the 33rd wraps.
    for (int k = 0; k < 33; k++) begin
      drive_beat(0, 131071, 131071);
      tick();
    end
    v = 0; a = '0; b = '0;
    tick();
    chk("ovf40_after32", longint'(ovf1), 0);
    chk("p40_after32", longint'(p1), 64'sd549747425312);
    tick();
    chk("ovf40_after33", longint'(ovf1), 1);
    if (SAT) chk("p40_sat", longint'(p1), (64'sd1 <<< 39) - 1);
    else     chk("p40_wrap", longint'(p1), -64'sd532584595423);
    chk("ovf48_after33", longint'(ovf0), 0);
    drive_beat(1, 0, 0);
    tick();
    drive_beat(1, 1, 1);
    tick();
    v = 0; l = 0; a = '0; b = '0;
    tick();
    chk("ovf40_sticky", longint'(ovf1), 1);
    chk("cnt40_frame", longint'(cnt1), 34);
    tick();
    chk("ovf40_cleared", longint'(ovf1), 0);
    chk("p40_newframe", longint'(p1), 1);
    chk("cnt40_newframe", longint'(cnt1), 1);

    // Randomised traffic checked by the model alone.
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      ce   = ($urandom_range(0, 7) != 0);
      v    = ($urandom_range(0, 3) != 0);
      l    = ($urandom_range(0, 5) == 0);
      mode = 4'($urandom);
      a    = 18'($urandom);
      b    = 18'($urandom);
      d    = 18'($urandom);
      c    = 48'({$urandom, $urandom});
      pcin = 48'({$urandom, $urandom});
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
